// File: rtl/dlx_hazard_ctrl.sv
// rtl/dlx_hazard_ctrl.sv - DLX pipeline hazard, forwarding and flush controller
//
// Tracks destination registers of in-flight instructions (EX, MEM, WB, ...)
// in a shift-register scoreboard and derives operand-forwarding selects,
// load-use stalls and branch/jump flushes for the instruction in ID.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   id_valid                     ID holds a real instruction
//   id_rs1/id_rs2, *_used        source addresses and whether they are read
//   id_rd, id_wr, id_is_load     destination, write enable, load flag
//   ex_redirect                  taken branch/jump resolved in EX
//   stall                        hold PC and IF/ID, bubble into EX
//   flush_if, flush_id           squash IF/ID and ID/EX
//   fwd_a, fwd_b                 0 = register file, k+1 = scoreboard entry k
//   stall_count, flush_count     saturating performance counters
module dlx_hazard_ctrl #(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CW         = 16,
  parameter int FW         = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [AW-1:0] id_rd,
  input  logic          id_wr,
  input  logic          id_is_load,
  input  logic          ex_redirect,
  output logic          stall,
  output logic          flush_if,
  output logic          flush_id,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  logic [DEPTH-1:0]         sb_valid_q, sb_valid_d;
  logic [DEPTH-1:0]         sb_load_q,  sb_load_d;
  logic [DEPTH-1:0][AW-1:0] sb_rd_q,    sb_rd_d;
  logic [CW-1:0]            stall_count_q, stall_count_d;
  logic [CW-1:0]            flush_count_q, flush_count_d;

  logic [FW-1:0] sel_a, sel_b;
  logic          a_load_early, b_load_early;
  logic          stall_int;
  logic          issue;

  // Walk from oldest to youngest so the youngest matching producer is the
  // last one assigned. The stall decision follows that same producer, so an
  // older load shadowed by a younger ALU write does not stall.
  always_comb begin
    sel_a        = '0;
    sel_b        = '0;
    a_load_early = 1'b0;
    b_load_early = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_valid_q[k] && (sb_rd_q[k] == id_rs1) && (id_rs1 != '0) && id_rs1_used) begin
        sel_a        = FW'(k + 1);
        a_load_early = sb_load_q[k] && (k < LOAD_STAGE);
      end
      if (sb_valid_q[k] && (sb_rd_q[k] == id_rs2) && (id_rs2 != '0) && id_rs2_used) begin
        sel_b        = FW'(k + 1);
        b_load_early = sb_load_q[k] && (k < LOAD_STAGE);
      end
    end
  end

  // A redirect squashes the ID instruction, so it never needs to wait.
  assign stall_int = !reset && id_valid && !ex_redirect && (a_load_early || b_load_early);
  assign issue     = id_valid && !stall_int && !ex_redirect;

  assign stall       = stall_int;
  assign flush_if    = !reset && ex_redirect;
  assign flush_id    = !reset && ex_redirect;
  assign fwd_a       = (!reset && id_valid) ? sel_a : '0;
  assign fwd_b       = (!reset && id_valid) ? sel_b : '0;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_load_d  = sb_load_q;
    sb_rd_d    = sb_rd_q;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      sb_valid_d[k] = sb_valid_q[k-1];
      sb_load_d[k]  = sb_load_q[k-1];
      sb_rd_d[k]    = sb_rd_q[k-1];
    end
    // Writes to r0 enter as invalid so they can never be forwarded.
    sb_valid_d[0] = issue && id_wr && (id_rd != '0);
    sb_load_d[0]  = issue && id_is_load;
    sb_rd_d[0]    = id_rd;

    stall_count_d = stall_count_q;
    if (stall_int && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CW'(1);
    end
    flush_count_d = flush_count_q;
    if (ex_redirect && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_valid_q    <= '0;
      sb_load_q     <= '0;
      sb_rd_q       <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      sb_valid_q    <= sb_valid_d;
      sb_load_q     <= sb_load_d;
      sb_rd_q       <= sb_rd_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// tb/tb_dlx_hazard_ctrl.sv - scoreboard bench for dlx_hazard_ctrl
module tb_dlx_hazard_ctrl;
  localparam int AW = 5;
  localparam int DEPTH = 3;
  localparam int LOAD_STAGE = 1;
  localparam int CW = 4;
  localparam int FW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_rs1_used, id_rs2_used, id_wr, id_is_load, ex_redirect;
  logic          stall, flush_if, flush_id;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clock = ~clock;

  dlx_hazard_ctrl #(
    .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CW(CW), .FW(FW)
  ) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .stall(stall),
    .flush_if(flush_if), .flush_id(flush_id),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct {
    string name;
    int    st;
    int    fl;
    int    fa;
    int    fb;
    int    sc;
    int    fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Monitor: sample mid-cycle, pop one expectation per presented cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".stall"},       int'(stall),       e.st);
        chk({e.name, ".flush_if"},    int'(flush_if),    e.fl);
        chk({e.name, ".flush_id"},    int'(flush_id),    e.fl);
        chk({e.name, ".fwd_a"},       int'(fwd_a),       e.fa);
        chk({e.name, ".fwd_b"},       int'(fwd_b),       e.fb);
        chk({e.name, ".stall_count"}, int'(stall_count), e.sc);
        chk({e.name, ".flush_count"}, int'(flush_count), e.fc);
      end
    end
  end

  task automatic drive(input logic v, input int r1, input logic u1, input int r2,
                       input logic u2, input int rd, input logic wr, input logic ld,
                       input logic rdr);
    id_valid    = v;
    id_rs1      = AW'(r1);
    id_rs1_used = u1;
    id_rs2      = AW'(r2);
    id_rs2_used = u2;
    id_rd       = AW'(rd);
    id_wr       = wr;
    id_is_load  = ld;
    ex_redirect = rdr;
  endtask

  task automatic push(input string nm, input int st, input int fl, input int fa,
                      input int fb, input int sc, input int fc);
    exp_t e;
    e.name = nm; e.st = st; e.fl = fl; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int st, fa, sc, waited;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Outputs held at zero during reset regardless of ID inputs.
    next_cycle(); drive(1, 3, 1, 3, 1, 3, 1, 1, 1); push("in_reset", 0, 0, 0, 0, 0, 0);
    next_cycle(); reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push("idle", 0, 0, 0, 0, 0, 0);

    // Back-to-back ALU dependencies.
    next_cycle(); drive(1, 1, 1, 2, 1, 3, 1, 0, 0);  push("alu_first", 0, 0, 0, 0, 0, 0);
    next_cycle(); drive(1, 3, 1, 5, 1, 4, 1, 0, 0);  push("alu_dep_ex", 0, 0, 1, 0, 0, 0);
    next_cycle(); drive(1, 3, 1, 4, 1, 8, 1, 0, 0);  push("alu_dep_mem", 0, 0, 2, 1, 0, 0);
    // Load-use: one-cycle bubble then forward from MEM.
    next_cycle(); drive(1, 1, 1, 0, 0, 6, 1, 1, 0);  push("lw_issue", 0, 0, 0, 0, 0, 0);
    next_cycle(); drive(1, 6, 1, 6, 1, 7, 1, 0, 0);  push("load_use_stall", 1, 0, 1, 1, 0, 0);
    next_cycle();                                     push("load_use_release", 0, 0, 2, 2, 1, 0);
    // Register 0 never matches.
    next_cycle(); drive(1, 1, 1, 0, 0, 0, 1, 1, 0);  push("lw_r0", 0, 0, 0, 0, 1, 0);
    next_cycle(); drive(1, 0, 1, 7, 1, 9, 1, 0, 0);  push("r0_no_match", 0, 0, 0, 2, 1, 0);
    // Redirect in the cycle a load-use stall would assert.
    next_cycle(); drive(1, 0, 0, 0, 0, 10, 1, 1, 0); push("lw_r10", 0, 0, 0, 0, 1, 0);
    next_cycle(); drive(1, 10, 1, 2, 1, 11, 1, 0, 1); push("redirect_wins", 0, 1, 1, 0, 1, 0);
    next_cycle(); drive(1, 11, 1, 10, 1, 12, 1, 0, 0); push("bubble_after_flush", 0, 0, 0, 2, 1, 1);
    // Younger non-load shadows an older load of the same register.
    next_cycle(); drive(1, 0, 1, 0, 0, 13, 1, 1, 0); push("lw_r13", 0, 0, 0, 0, 1, 1);
    next_cycle(); drive(1, 12, 1, 0, 0, 13, 1, 0, 0); push("alu_after_lw", 0, 0, 2, 0, 1, 1);
    next_cycle(); drive(1, 13, 1, 13, 1, 14, 1, 0, 0); push("youngest_nonload", 0, 0, 1, 1, 1, 1);
    // id_valid low forces selects to zero; unused sources never forward.
    next_cycle(); drive(0, 14, 1, 14, 1, 0, 0, 0, 0); push("idle_fwd_zero", 0, 0, 0, 0, 1, 1);
    next_cycle(); drive(1, 14, 0, 14, 1, 0, 0, 0, 0); push("used_bit", 0, 0, 0, 2, 1, 1);

    // Chain of self-dependent loads: stall on every other cycle, 20 stalls,
    // counter (CW=4) must stop at 15.
    for (int i = 0; i <= 40; i++) begin
      next_cycle();
      drive(1, 6, 1, 0, 0, 6, 1, 1, 0);
      st = (i % 2 == 1) ? 1 : 0;
      fa = (i == 0) ? 0 : (st == 1 ? 1 : 2);
      sc = 1 + i / 2;
      if (sc > 15) sc = 15;
      push($sformatf("sat_%0d", i), st, 0, fa, 0, sc, 1);
    end

    // Asynchronous reset between edges while a load-use match is present.
    next_cycle(); drive(1, 6, 1, 0, 0, 6, 1, 1, 0);
    #1 reset = 1'b1;
    push("reset_mid_stall", 0, 0, 0, 0, 0, 0);
    next_cycle(); reset = 1'b0;
    drive(0, 6, 1, 6, 1, 6, 1, 1, 0); push("post_reset_idle", 0, 0, 0, 0, 0, 0);
    next_cycle();                     push("post_reset_idle2", 0, 0, 0, 0, 0, 0);
    next_cycle(); drive(1, 6, 1, 6, 1, 6, 1, 1, 0); push("no_restall", 0, 0, 0, 0, 0, 0);
    next_cycle();                     push("new_load_stalls", 1, 0, 1, 1, 0, 0);

    next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clock);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
